// File: rtl/dbus_ctrl.sv
// dbus_ctrl: memory-stage data-bus sequencer.
// Takes one load/store from the memory stage and issues it on the data bus.
// Stores go out with byte strobes and lane-shifted data. Loads have their
// lanes extracted and extended. Misaligned accesses are answered directly
// and never reach the bus.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new access; req_ready=1
// REQ   | bus request outstanding; dreq_* held until dresp_data_ok
// RESP  | result (or misalign fault) held until writeback takes it
module dbus_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_msize,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign
);

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;
  localparam logic [1:0] MSIZE8 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        write_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic        misalign_q;
  logic [63:0] rdata_q;
  logic        drop_q;

  logic        accept;
  logic        misalign_in;
  logic [7:0]  strobe_base;
  logic [7:0]  strobe_in;
  logic [63:0] store_data_in;
  logic [63:0] load_shifted;
  logic [63:0] load_ext;

  assign accept = (state_q == S_IDLE) && req_valid;

  // Alignment check on the incoming request; byte accesses are always aligned.
  always_comb begin
    misalign_in = 1'b0;
    case (req_msize)
      MSIZE1:  misalign_in = 1'b0;
      MSIZE2:  misalign_in = req_addr[0];
      MSIZE4:  misalign_in = |req_addr[1:0];
      MSIZE8:  misalign_in = |req_addr[2:0];
      default: misalign_in = 1'b0;
    endcase
  end

  // Byte-enable pattern and lane-shifted store data for the incoming request.
  always_comb begin
    strobe_base = 8'h00;
    case (req_msize)
      MSIZE1:  strobe_base = 8'h01;
      MSIZE2:  strobe_base = 8'h03;
      MSIZE4:  strobe_base = 8'h0F;
      MSIZE8:  strobe_base = 8'hFF;
      default: strobe_base = 8'h00;
    endcase
    strobe_in     = strobe_base << req_addr[2:0];
    store_data_in = req_wdata << {req_addr[2:0], 3'b000};
  end

  // Load lane extraction: shifting by the byte offset works for every size
  // because aligned offsets are multiples of the access size.
  always_comb begin
    load_shifted = dresp_data >> {addr_q[2:0], 3'b000};
    load_ext     = 64'd0;
    case (size_q)
      MSIZE1:  load_ext = unsigned_q ? {56'd0, load_shifted[7:0]}
                                     : {{56{load_shifted[7]}}, load_shifted[7:0]};
      MSIZE2:  load_ext = unsigned_q ? {48'd0, load_shifted[15:0]}
                                     : {{48{load_shifted[15]}}, load_shifted[15:0]};
      MSIZE4:  load_ext = unsigned_q ? {32'd0, load_shifted[31:0]}
                                     : {{32{load_shifted[31]}}, load_shifted[31:0]};
      MSIZE8:  load_ext = load_shifted;
      default: load_ext = load_shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a flush seen at any point in REQ sends the completed
  // transaction straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = misalign_in ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (dresp_data_ok) state_d = (drop_q || flush) ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    req_ready  = 1'b0;
    dreq_valid = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE:  req_ready  = 1'b1;
      S_REQ:   dreq_valid = 1'b1;
      S_RESP:  resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Request latch, load result capture and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q     <= 64'd0;
      size_q     <= MSIZE1;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      strobe_q   <= 8'h00;
      wdata_q    <= 64'd0;
      misalign_q <= 1'b0;
      rdata_q    <= 64'd0;
      drop_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        size_q     <= req_msize;
        unsigned_q <= req_unsigned;
        write_q    <= req_write;
        strobe_q   <= (req_write && !misalign_in) ? strobe_in : 8'h00;
        wdata_q    <= (req_write && !misalign_in) ? store_data_in : 64'd0;
        misalign_q <= misalign_in;
        rdata_q    <= 64'd0;
        drop_q     <= 1'b0;
      end
      if (state_q == S_REQ) begin
        if (dresp_data_ok) begin
          rdata_q <= write_q ? 64'd0 : load_ext;
          drop_q  <= 1'b0;
        end else if (flush) begin
          drop_q  <= 1'b1;
        end
      end
    end
  end

  assign dreq_addr     = addr_q;
  assign dreq_size     = size_q;
  assign dreq_strobe   = strobe_q;
  assign dreq_data     = wdata_q;
  assign resp_rdata    = rdata_q;
  assign resp_misalign = misalign_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: loads, stores, misalign, stalls, flush, reset.
module tb_dbus_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_write, req_unsigned, flush;
  logic        req_ready;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_msize;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        resp_valid, resp_ready, resp_misalign;
  logic [63:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  dbus_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_msize(req_msize), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_misalign(resp_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single accept edge, then withdraw it.
  task automatic issue(input logic wr, input logic [63:0] a, input logic [1:0] sz,
                       input logic uns, input logic [63:0] wd);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_msize = sz;
    req_unsigned = uns; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic bus_ok(input logic [63:0] d);
    dresp_data_ok = 1'b1; dresp_data = d;
    tick();
    dresp_data_ok = 1'b0; dresp_data = 64'd0;
  endtask

  task automatic take();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0;
    req_msize = 2'd0; req_unsigned = 1'b0; req_wdata = 64'd0; flush = 1'b0;
    dresp_data_ok = 1'b0; dresp_data = 64'd0; resp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    resetn = 1'b1;
    tick();

    // LB at ...03, byte3 = 0x80 -> sign-extended
    issue(1'b0, 64'h1000_0003, 2'd0, 1'b0, 64'd0);
    chk("lb_dreq_valid", 64'(dreq_valid), 64'd1);
    chk("lb_req_ready", 64'(req_ready), 64'd0);
    chk("lb_strobe", 64'(dreq_strobe), 64'h00);
    chk("lb_addr", dreq_addr, 64'h1000_0003);
    bus_ok(64'h0000_0000_8000_0000);
    chk("lb_resp_valid", 64'(resp_valid), 64'd1);
    chk("lb_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_misalign", 64'(resp_misalign), 64'd0);
    take();
    chk("lb_idle", 64'(req_ready), 64'd1);

    // LBU same access -> zero-extended
    issue(1'b0, 64'h1000_0003, 2'd0, 1'b1, 64'd0);
    bus_ok(64'h0000_0000_8000_0000);
    chk("lbu_rdata", resp_rdata, 64'h0000_0000_0000_0080);
    take();

    // LW at ...04 signed: upper word
    issue(1'b0, 64'h2000_0004, 2'd2, 1'b0, 64'd0);
    bus_ok(64'h8765_4321_1111_2222);
    chk("lw_rdata", resp_rdata, 64'hFFFF_FFFF_8765_4321);
    take();

    // LHU at ...02
    issue(1'b0, 64'h2000_0002, 2'd1, 1'b1, 64'd0);
    bus_ok(64'h0000_0000_F00D_0000);
    chk("lhu_rdata", resp_rdata, 64'h0000_0000_0000_F00D);
    take();

    // SH at ...06 with 0xBEEF
    issue(1'b1, 64'h3000_0006, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF);
    chk("sh_strobe", 64'(dreq_strobe), 64'hC0);
    chk("sh_data", dreq_data, 64'hBEEF_0000_0000_0000);
    chk("sh_size", 64'(dreq_size), 64'd1);
    bus_ok(64'hFFFF_FFFF_FFFF_FFFF);
    chk("sh_resp_valid", 64'(resp_valid), 64'd1);
    chk("sh_rdata", resp_rdata, 64'd0);
    take();

    // SW at ...04
    issue(1'b1, 64'h3000_0004, 2'd2, 1'b0, 64'h0000_0000_CAFE_F00D);
    chk("sw_strobe", 64'(dreq_strobe), 64'hF0);
    chk("sw_data", dreq_data, 64'hCAFE_F00D_0000_0000);
    bus_ok(64'd0);
    take();

    // LW at ...02 misaligned: no bus traffic, answered next cycle
    issue(1'b0, 64'h4000_0002, 2'd2, 1'b0, 64'd0);
    chk("mis_resp_valid", 64'(resp_valid), 64'd1);
    chk("mis_flag", 64'(resp_misalign), 64'd1);
    chk("mis_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("mis_rdata", resp_rdata, 64'd0);
    take();
    chk("mis_idle", 64'(req_ready), 64'd1);
    chk("mis_idle_dreq", 64'(dreq_valid), 64'd0);

    // SD at ...04 misaligned
    issue(1'b1, 64'h4000_0004, 2'd3, 1'b0, 64'h1234);
    chk("sd_mis_flag", 64'(resp_misalign), 64'd1);
    chk("sd_mis_strobe", 64'(dreq_strobe), 64'h00);
    take();

    // LD with bus delayed 5 cycles and writeback stalled 3 cycles
    issue(1'b0, 64'h5000_0008, 2'd3, 1'b0, 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("ld_wait_valid", 64'(dreq_valid), 64'd1);
      chk("ld_wait_addr", dreq_addr, 64'h5000_0008);
      chk("ld_wait_size", 64'(dreq_size), 64'd3);
      chk("ld_wait_strobe", 64'(dreq_strobe), 64'h00);
      tick();
    end
    bus_ok(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_valid", 64'(resp_valid), 64'd1);
      chk("ld_stall_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
      tick();
    end
    chk("ld_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
    take();
    chk("ld_idle", 64'(req_ready), 64'd1);
    chk("ld_idle_resp", 64'(resp_valid), 64'd0);

    // Flush during REQ, data_ok later: result dropped
    issue(1'b0, 64'h6000_0000, 2'd3, 1'b0, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flq_still_req", 64'(dreq_valid), 64'd1);
    tick();
    bus_ok(64'hAAAA_AAAA_AAAA_AAAA);
    chk("flq_no_resp", 64'(resp_valid), 64'd0);
    chk("flq_ready", 64'(req_ready), 64'd1);

    // Flush together with data_ok: result dropped
    issue(1'b0, 64'h6000_0010, 2'd3, 1'b0, 64'd0);
    flush = 1'b1;
    bus_ok(64'h5555_5555_5555_5555);
    flush = 1'b0;
    chk("flsame_no_resp", 64'(resp_valid), 64'd0);
    chk("flsame_ready", 64'(req_ready), 64'd1);

    // Flush in IDLE does not block acceptance; next access runs normally
    flush = 1'b1;
    issue(1'b0, 64'h7000_0001, 2'd0, 1'b1, 64'd0);
    flush = 1'b0;
    chk("fli_accepted", 64'(dreq_valid), 64'd1);
    bus_ok(64'h0000_0000_0000_7F00);
    chk("fli_resp_valid", 64'(resp_valid), 64'd1);
    chk("fli_rdata", resp_rdata, 64'h0000_0000_0000_007F);

    // Flush in RESP with resp_ready low -> IDLE next cycle
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flr_no_resp", 64'(resp_valid), 64'd0);
    chk("flr_ready", 64'(req_ready), 64'd1);

    // Reset pulled during REQ
    issue(1'b1, 64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_0000_00A5);
    chk("rr_dreq_valid", 64'(dreq_valid), 64'd1);
    chk("rr_strobe_pre", 64'(dreq_strobe), 64'h08);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rr_dreq_valid0", 64'(dreq_valid), 64'd0);
    chk("rr_ready", 64'(req_ready), 64'd1);
    chk("rr_addr", dreq_addr, 64'd0);
    chk("rr_data", dreq_data, 64'd0);
    chk("rr_strobe", 64'(dreq_strobe), 64'h00);
    chk("rr_resp_valid", 64'(resp_valid), 64'd0);
    chk("rr_rdata", resp_rdata, 64'd0);
    chk("rr_misalign", 64'(resp_misalign), 64'd0);
    tick();
    chk("rr_stay_idle", 64'(req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
